pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//   Top-level match sequencer for Pong. Drives the shared 2-bit game state
//   (START/SERVE/PLAY/DONE) and serve direction into the ball engine.
//   Consumes the ball engine's point status, keeps both scores and declares
//   the winner. Sits between the debounced button inputs and the ball/paddle
//   datapath. Its score outputs feed the display.
// PARAMETERS
//   WIN_SCORE    7           points needed to win a match (1..15)
//   SERVE_DELAY  25_000_000  clocks spent in SERVE before PLAY (>=2; 1 s @25 MHz)
//   CNT_W        25          width of serve-delay counter (2^CNT_W > SERVE_DELAY)
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous reset, active-low
//   start_btn    in   1  debounced start button, level; rising edge is used
//   ball_status  in   2  from ball engine: 00 PLAYING, 01 P1 point, 10 P2 point
//   state        out  2  00 START, 01 SERVE, 10 PLAY, 11 DONE
//   serve        out  1  serve direction: 0 = launch right (toward P2), 1 = left (toward P1)
//   score1       out  4  player-1 score
//   score2       out  4  player-2 score
//   winner       out  2  00 none, 01 P1, 10 P2; valid in DONE
//   point_p      out  1  one-cycle pulse on each scored point
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=START, serve=0, score1=score2=0, winner=00,
//     point_p=0, delay counter=0, start-edge register=0. Applies mid-match.
//   - start_btn: registered once; start_rise = start_btn & ~start_btn_q.
//   - START: scores and winner held at 0. On start_rise -> SERVE next clock.
//   - SERVE: delay counter counts 0..SERVE_DELAY-1; at SERVE_DELAY-1 ->
//     PLAY and counter clears. ball_status is ignored in SERVE. The ball engine
//     returns to PLAYING within one clock of SERVE, so no point is counted twice.
//   - PLAY: ball_status==01 -> score1+1, serve<=0, point_p=1 for one clock.
//     ball_status==10 -> score2+1, serve<=1, point_p=1.
//     Code 11 is treated as 00. Status is checked only in PLAY, one point per PLAY visit.
//     After scoring: if win condition holds -> DONE with winner set, else -> SERVE.
//     Score and state update on the same clock edge.
//   - Win condition (default): new score == WIN_SCORE.
//   - Scores saturate at 15; no wrap-around.
//   - DONE: scores and winner frozen. On start_rise -> START, which clears the
//     scores and winner on the next clock. serve is kept across matches.
//   - start_btn in SERVE or PLAY is ignored. The edge register still tracks it.
//   - Output latency: all outputs are registered; state changes 1 clock after the
//     qualifying input.
// CONFIGURATION
//   WIN_BY_TWO_EN defined:
//     - A win requires new score >= WIN_SCORE and a lead >= 2.
//     - If a score would exceed 15, the player reaching 15 wins immediately.
//   WIN_BY_TWO_EN undefined: the win condition is exactly the default above.
// STRUCTURE
//   - Package pong_pkg holds:
//     - state codes START/SERVE/PLAY/DONE;
//     - ball status codes PLAYING/PLAYER1WIN/PLAYER2WIN;
//     - ORIGINX/ORIGINY;
//     - the winner encoding.
//     The ball engine and this block import it.
//   - Sub-module btn_edge: one-flop rising-edge detector with async active-low reset.
//     It is reused for start_btn.
//   - Everything else (FSM, scores, delay counter) is inline.
// TESTING
//   - Reset mid-PLAY with score1=3: assert rst_n=0 -> state=00, scores 0, winner 00 immediately.
//   - Serve timing: SERVE_DELAY=4, start_rise in START -> SERVE next clk, PLAY exactly 4 clks later.
//   - P1 point: ball_status=01 in PLAY (held 3 clks) -> score1 0->1 once, serve=0, point_p one clk, state=SERVE.
//   - Match end: WIN_SCORE=3, score2=2, status=10 -> score2=3, state=DONE, winner=10; start_rise -> START, scores 0.
//   - Held start_btn: start_btn held high through START->SERVE->PLAY -> only one transition.
//     Re-press in PLAY -> no effect.
//   - WIN_BY_TWO_EN, WIN_SCORE=3: scores 3-3 then P1 point -> 4-3 SERVE.
//     Then another P1 point -> 5-3, DONE, winner=01.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state codes, ball status codes, the
// playfield origin and the winner encoding. Imported by the match
// sequencer and the ball engine.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    BS_PLAYING    = 2'b00,
    BS_PLAYER1WIN = 2'b01,
    BS_PLAYER2WIN = 2'b10
  } ball_status_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Ball launch position (centre of a 640x480 playfield)
  localparam int ORIGINX = 320;
  localparam int ORIGINY = 240;

  // Score increment that sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// btn_edge: one-flop rising-edge detector for a debounced level input.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  // Remember last cycle's button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer. Steps START -> SERVE -> PLAY ->
// (SERVE | DONE), keeps both scores, serve direction and the winner.
// Optional build macro: WIN_BY_TWO_EN (win needs a 2-point lead; reaching
// 15 wins outright).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic [1:0] ball_status,
  output logic [1:0] state,
  output logic       serve,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic       point_p
);

  localparam logic [3:0]       WIN_Q      = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

  game_state_e      state_q;
  winner_e          winner_q;
  logic             serve_q;
  logic             point_q;
  logic [3:0]       score1_q;
  logic [3:0]       score2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_rise;
  logic [3:0]       s1_inc;
  logic [3:0]       s2_inc;
  logic             p1_wins;
  logic             p2_wins;

  btn_edge u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (start_btn),
    .rise_o (start_rise)
  );

  assign s1_inc = sat_inc(score1_q);
  assign s2_inc = sat_inc(score2_q);

`ifdef WIN_BY_TWO_EN
  // Deuce rule: need WIN_SCORE and a 2-point lead; hitting the 15 ceiling ends it
  assign p1_wins = (s1_inc == 4'd15) ||
                   ((s1_inc >= WIN_Q) && ({1'b0, s1_inc} >= ({1'b0, score2_q} + 5'd2)));
  assign p2_wins = (s2_inc == 4'd15) ||
                   ((s2_inc >= WIN_Q) && ({1'b0, s2_inc} >= ({1'b0, score1_q} + 5'd2)));
`else
  assign p1_wins = (s1_inc == WIN_Q);
  assign p2_wins = (s2_inc == WIN_Q);
`endif

  // Match FSM with registered scores, serve direction, winner and point pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_START;
      winner_q <= WIN_NONE;
      serve_q  <= 1'b0;
      point_q  <= 1'b0;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      cnt_q    <= '0;
    end else begin
      point_q <= 1'b0;
      case (state_q)
        ST_START: begin
          score1_q <= 4'd0;
          score2_q <= 4'd0;
          winner_q <= WIN_NONE;
          cnt_q    <= '0;
          if (start_rise) state_q <= ST_SERVE;
        end
        ST_SERVE: begin
          // ball_status is deliberately ignored while the ball is re-centred
          if (cnt_q == SERVE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_PLAY;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // Leaving PLAY on any point guarantees one point per rally
          if (ball_status == BS_PLAYER1WIN) begin
            score1_q <= s1_inc;
            serve_q  <= 1'b0;
            point_q  <= 1'b1;
            if (p1_wins) begin
              state_q  <= ST_DONE;
              winner_q <= WIN_P1;
            end else begin
              state_q <= ST_SERVE;
            end
          end else if (ball_status == BS_PLAYER2WIN) begin
            score2_q <= s2_inc;
            serve_q  <= 1'b1;
            point_q  <= 1'b1;
            if (p2_wins) begin
              state_q  <= ST_DONE;
              winner_q <= WIN_P2;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        ST_DONE: begin
          // Scores stay frozen for display; START clears them a clock later
          if (start_rise) state_q <= ST_START;
        end
        default: state_q <= ST_START;
      endcase
    end
  end

  assign state   = state_q;
  assign serve   = serve_q;
  assign score1  = score1_q;
  assign score2  = score2_q;
  assign winner  = winner_q;
  assign point_p = point_q;

endmodule
